uc_sequencer: RTL and testbench

Microcode sequencer that expands multi-cycle MUL/MULS instructions held in IF/ID into a stream of micro-ops for the ID stage. On trigger it stalls fetch, walks a fixed micro-ROM with a hardware loop counter (shift-add multiply), and hands each micro-op over a valid/ready handshake. It then releases IF/ID so the pipeline advances past the macro instruction. It sits between the IF/ID register and the decoder, alongside the existing micro-op trigger logic.

---
 rtl/uc_pkg.sv | 67 ++++++
 rtl/uc_sequencer_if.sv | 15 +
 rtl/uc_rom.sv | 37 +++
 rtl/uc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_uc_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uc_pkg.sv
// Shared types for the MUL/MULS microcode sequencer: micro-op codes, operand
// selectors, FSM states, trigger opcodes, ROM entry layout and selector resolution.
package uc_pkg;

  typedef enum logic [3:0] {
    UOP_NOP   = 4'd0,
    UOP_MOVI  = 4'd1,
    UOP_MOV   = 4'd2,
    UOP_ADDIF = 4'd3,
    UOP_SHL   = 4'd4,
    UOP_SHR   = 4'd5,
    UOP_ABS   = 4'd6,
    UOP_SGNX  = 4'd7,
    UOP_NEGIF = 4'd8
  } uop_op_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RD   = 3'd1,
    SEL_RN   = 3'd2,
    SEL_RM   = 3'd3,
    SEL_T0   = 3'd4,
    SEL_T1   = 3'd5,
    SEL_T2   = 3'd6,
    SEL_T3   = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OPC_MUL    = 7'b0010000;
  localparam logic [6:0] OPC_MULS   = 7'b0011000;
  localparam logic [3:0] ENTRY_MUL  = 4'd0;
  localparam logic [3:0] ENTRY_MULS = 4'd8;
  // Loop body is three micro-ops; loop_end sits on the third, so jump back by two.
  localparam logic [3:0] LOOP_BACK  = 4'd2;

  typedef struct packed {
    uop_op_e op;
    sel_e    rd_sel;
    sel_e    rn_sel;
    sel_e    rm_sel;
    logic    loop_end;
    logic    last;
  } rom_entry_t;

  // Bit 4 set marks a micro-temp T[1:0]; otherwise an architectural R[3:0].
  function automatic logic [4:0] resolve_sel(sel_e sel, logic [3:0] rd, logic [3:0] rn,
                                             logic [3:0] rm);
    logic [4:0] spec;
    case (sel)
      SEL_RD:  spec = {1'b0, rd};
      SEL_RN:  spec = {1'b0, rn};
      SEL_RM:  spec = {1'b0, rm};
      SEL_T0:  spec = 5'b10000;
      SEL_T1:  spec = 5'b10001;
      SEL_T2:  spec = 5'b10010;
      SEL_T3:  spec = 5'b10011;
      default: spec = 5'b00000;
    endcase
    return spec;
  endfunction

endpackage

// File: rtl/uc_sequencer_if.sv
// Micro-op valid/ready channel from the sequencer (master) to the ID stage (slave).
interface uc_sequencer_if;
  logic             uop_valid;
  logic             uop_ready;
  uc_pkg::uop_op_e  uop_op;
  logic [4:0]       uop_rd;
  logic [4:0]       uop_rn;
  logic [4:0]       uop_rm;
  logic             uop_last;

  modport master (output uop_valid, uop_op, uop_rd, uop_rn, uop_rm, uop_last,
                  input  uop_ready);
  modport slave  (input  uop_valid, uop_op, uop_rd, uop_rn, uop_rm, uop_last,
                  output uop_ready);
endinterface

// File: rtl/uc_rom.sv
// 16-entry combinational micro-ROM holding the MUL (entry 0) and MULS (entry 8)
// shift-add programs.
module uc_rom
  import uc_pkg::*;
(
  input  logic [3:0] addr,
  output rom_entry_t entry
);

  function automatic rom_entry_t ent(uop_op_e op, sel_e d, sel_e n, sel_e m,
                                     logic le, logic la);
    return '{op, d, n, m, le, la};
  endfunction

  always_comb begin
    entry = ent(UOP_NOP, SEL_NONE, SEL_NONE, SEL_NONE, 1'b0, 1'b0);
    case (addr)
      4'd0:    entry = ent(UOP_MOVI,  SEL_T1, SEL_NONE, SEL_NONE, 1'b0, 1'b0);
      4'd1:    entry = ent(UOP_MOV,   SEL_T2, SEL_RN,   SEL_NONE, 1'b0, 1'b0);
      4'd2:    entry = ent(UOP_MOV,   SEL_T3, SEL_RM,   SEL_NONE, 1'b0, 1'b0);
      4'd3:    entry = ent(UOP_ADDIF, SEL_T1, SEL_T1,   SEL_T2,   1'b0, 1'b0);
      4'd4:    entry = ent(UOP_SHL,   SEL_T2, SEL_T2,   SEL_NONE, 1'b0, 1'b0);
      4'd5:    entry = ent(UOP_SHR,   SEL_T3, SEL_T3,   SEL_NONE, 1'b1, 1'b0);
      4'd6:    entry = ent(UOP_MOV,   SEL_RD, SEL_T1,   SEL_NONE, 1'b0, 1'b1);
      4'd8:    entry = ent(UOP_MOVI,  SEL_T1, SEL_NONE, SEL_NONE, 1'b0, 1'b0);
      4'd9:    entry = ent(UOP_ABS,   SEL_T2, SEL_RN,   SEL_NONE, 1'b0, 1'b0);
      4'd10:   entry = ent(UOP_ABS,   SEL_T3, SEL_RM,   SEL_NONE, 1'b0, 1'b0);
      4'd11:   entry = ent(UOP_SGNX,  SEL_T0, SEL_RN,   SEL_RM,   1'b0, 1'b0);
      4'd12:   entry = ent(UOP_ADDIF, SEL_T1, SEL_T1,   SEL_T2,   1'b0, 1'b0);
      4'd13:   entry = ent(UOP_SHL,   SEL_T2, SEL_T2,   SEL_NONE, 1'b0, 1'b0);
      4'd14:   entry = ent(UOP_SHR,   SEL_T3, SEL_T3,   SEL_NONE, 1'b1, 1'b0);
      4'd15:   entry = ent(UOP_NEGIF, SEL_RD, SEL_T1,   SEL_T0,   1'b0, 1'b1);
      default: entry = ent(UOP_NOP,   SEL_NONE, SEL_NONE, SEL_NONE, 1'b0, 1'b0);
    endcase
  end

endmodule

// File: rtl/uc_sequencer.sv
// Expands MUL/MULS held in IF/ID into a handshaked micro-op stream, stalling
// fetch until the macro instruction retires.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int unsigned LOOP_N = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifid_instr,
  input  logic        ifid_valid,
  input  logic        flush,
  output logic        hold_if,
  output logic        uc_active,
  output logic        seq_done,
  uc_sequencer_if.master uop
);

  localparam int unsigned CNT_W = (LOOP_N > 1) ? $clog2(LOOP_N) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOOP_N - 1);

  state_e           state_q, state_d;
  logic [3:0]       upc_q, upc_d;
  logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [3:0]       cap_rd_q, cap_rd_d, cap_rn_q, cap_rn_d, cap_rm_q, cap_rm_d;
  logic             uop_valid_q, uop_valid_d;
  uop_op_e          uop_op_q, uop_op_d;
  logic [4:0]       uop_rd_q, uop_rd_d, uop_rn_q, uop_rn_d, uop_rm_q, uop_rm_d;
  logic             uop_last_q, uop_last_d;
  logic             loop_end_q, loop_end_d;
  logic             seq_done_q, seq_done_d;

  logic             is_mul_s, is_muls_s, trigger_s, accept_s;
  rom_entry_t       entry_s;
  logic             unused_bits_s;

  assign is_mul_s      = (ifid_instr[31:25] == OPC_MUL);
  assign is_muls_s     = (ifid_instr[31:25] == OPC_MULS);
  assign trigger_s     = (state_q == ST_IDLE) && ifid_valid && (is_mul_s || is_muls_s)
                         && !flush && !rst;
  assign accept_s      = uop_valid_q && uop.uop_ready;
  assign unused_bits_s = ^ifid_instr[16:4];

  // The ROM is looked up at the next upc so that micro-op outputs come straight from flops.
  uc_rom u_rom (
    .addr  (upc_d),
    .entry (entry_s)
  );

  // Next-state, micro-PC, loop counter and operand capture.
  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    loop_cnt_d = loop_cnt_q;
    cap_rd_d   = cap_rd_q;
    cap_rn_d   = cap_rn_q;
    cap_rm_d   = cap_rm_q;
    if (flush) begin
      state_d    = ST_IDLE;
      upc_d      = 4'd0;
      loop_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_s) begin
            state_d    = ST_RUN;
            upc_d      = is_muls_s ? ENTRY_MULS : ENTRY_MUL;
            loop_cnt_d = CNT_INIT;
            cap_rd_d   = ifid_instr[24:21];
            cap_rn_d   = ifid_instr[20:17];
            cap_rm_d   = ifid_instr[3:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!accept_s) begin
            state_d = ST_RUN;
          end else if (uop_last_q) begin
            state_d    = ST_DONE;
            upc_d      = 4'd0;
            loop_cnt_d = '0;
          end else if (loop_end_q && (loop_cnt_q != '0)) begin
            loop_cnt_d = loop_cnt_q - CNT_W'(1);
            upc_d      = upc_q - LOOP_BACK;
          end else begin
            upc_d = upc_q + 4'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered micro-op and retire outputs.
  always_comb begin
    uop_valid_d = (state_d == ST_RUN);
    seq_done_d  = (state_d == ST_DONE);
    if (uop_valid_d) begin
      uop_op_d   = entry_s.op;
      uop_rd_d   = resolve_sel(entry_s.rd_sel, cap_rd_d, cap_rn_d, cap_rm_d);
      uop_rn_d   = resolve_sel(entry_s.rn_sel, cap_rd_d, cap_rn_d, cap_rm_d);
      uop_rm_d   = resolve_sel(entry_s.rm_sel, cap_rd_d, cap_rn_d, cap_rm_d);
      uop_last_d = entry_s.last;
      loop_end_d = entry_s.loop_end;
    end else begin
      uop_op_d   = UOP_NOP;
      uop_rd_d   = 5'd0;
      uop_rn_d   = 5'd0;
      uop_rm_d   = 5'd0;
      uop_last_d = 1'b0;
      loop_end_d = 1'b0;
    end
  end

  // All sequencer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      upc_q       <= 4'd0;
      loop_cnt_q  <= '0;
      cap_rd_q    <= 4'd0;
      cap_rn_q    <= 4'd0;
      cap_rm_q    <= 4'd0;
      uop_valid_q <= 1'b0;
      uop_op_q    <= UOP_NOP;
      uop_rd_q    <= 5'd0;
      uop_rn_q    <= 5'd0;
      uop_rm_q    <= 5'd0;
      uop_last_q  <= 1'b0;
      loop_end_q  <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      loop_cnt_q  <= loop_cnt_d;
      cap_rd_q    <= cap_rd_d;
      cap_rn_q    <= cap_rn_d;
      cap_rm_q    <= cap_rm_d;
      uop_valid_q <= uop_valid_d;
      uop_op_q    <= uop_op_d;
      uop_rd_q    <= uop_rd_d;
      uop_rn_q    <= uop_rn_d;
      uop_rm_q    <= uop_rm_d;
      uop_last_q  <= uop_last_d;
      loop_end_q  <= loop_end_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Fetch stalls in the trigger cycle itself, before the FSM leaves IDLE.
  assign hold_if       = trigger_s || (state_q == ST_RUN);
  assign uc_active     = trigger_s || (state_q == ST_RUN);
  assign seq_done      = seq_done_q;
  assign uop.uop_valid = uop_valid_q;
  assign uop.uop_op    = uop_op_q;
  assign uop.uop_rd    = uop_rd_q;
  assign uop.uop_rn    = uop_rn_q;
  assign uop.uop_rm    = uop_rm_q;
  assign uop.uop_last  = uop_last_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer: LOOP_N=32 instance for MUL, LOOP_N=4 instance for MULS.
module tb_uc_sequencer;
  import uc_pkg::*;

  localparam logic [4:0] T0 = 5'h10, T1 = 5'h11, T2 = 5'h12, T3 = 5'h13;

  logic        clk = 1'b0;
  logic        rst, ivalid, flush, rdy;
  logic [31:0] instr;
  logic        hold_a, act_a, done_a, hold_b, act_b, done_b;
  bit          sel;
  logic        m_valid, m_hold, m_act, m_done, m_last;
  logic [19:0] m_fld;
  int          checks = 0;
  int          failures = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  uc_sequencer_if ua ();
  uc_sequencer_if ub ();
  assign ua.uop_ready = rdy;
  assign ub.uop_ready = rdy;

  uc_sequencer #(.LOOP_N(32)) dut_a (
    .clk(clk), .rst(rst), .ifid_instr(instr), .ifid_valid(ivalid), .flush(flush),
    .hold_if(hold_a), .uc_active(act_a), .seq_done(done_a), .uop(ua.master));

  uc_sequencer #(.LOOP_N(4)) dut_b (
    .clk(clk), .rst(rst), .ifid_instr(instr), .ifid_valid(ivalid), .flush(flush),
    .hold_if(hold_b), .uc_active(act_b), .seq_done(done_b), .uop(ub.master));

  always_comb begin
    m_valid = sel ? ub.uop_valid : ua.uop_valid;
    m_hold  = sel ? hold_b : hold_a;
    m_act   = sel ? act_b  : act_a;
    m_done  = sel ? done_b : done_a;
    m_last  = sel ? ub.uop_last : ua.uop_last;
    m_fld   = sel ? {ub.uop_op, ub.uop_rd, ub.uop_rn, ub.uop_rm, ub.uop_last}
                  : {ua.uop_op, ua.uop_rd, ua.uop_rn, ua.uop_rm, ua.uop_last};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk_instr(logic [6:0] opc, logic [3:0] rd, logic [3:0] rn,
                                           logic [3:0] rm);
    return {opc, rd, rn, 13'd0, rm};
  endfunction

  function automatic logic [19:0] mk(uop_op_e op, logic [4:0] d, logic [4:0] n, logic [4:0] m,
                                     logic la);
    return {op, d, n, m, la};
  endfunction

  task automatic build(input bit muls, input int n, input logic [3:0] rd, input logic [3:0] rn,
                       input logic [3:0] rm);
    exp_q.delete();
    exp_q.push_back(mk(UOP_MOVI, T1, 5'd0, 5'd0, 1'b0));
    if (muls) begin
      exp_q.push_back(mk(UOP_ABS,  T2, {1'b0, rn}, 5'd0, 1'b0));
      exp_q.push_back(mk(UOP_ABS,  T3, {1'b0, rm}, 5'd0, 1'b0));
      exp_q.push_back(mk(UOP_SGNX, T0, {1'b0, rn}, {1'b0, rm}, 1'b0));
    end else begin
      exp_q.push_back(mk(UOP_MOV, T2, {1'b0, rn}, 5'd0, 1'b0));
      exp_q.push_back(mk(UOP_MOV, T3, {1'b0, rm}, 5'd0, 1'b0));
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(UOP_ADDIF, T1, T1, T2, 1'b0));
      exp_q.push_back(mk(UOP_SHL,   T2, T2, 5'd0, 1'b0));
      exp_q.push_back(mk(UOP_SHR,   T3, T3, 5'd0, 1'b0));
    end
    if (muls) exp_q.push_back(mk(UOP_NEGIF, {1'b0, rd}, T1, T0, 1'b1));
    else      exp_q.push_back(mk(UOP_MOV,   {1'b0, rd}, T1, 5'd0, 1'b1));
  endtask

  // Called at posedge+1 of the trigger cycle; ends at the negedge of the cycle after DONE/flush.
  // pat 0: ready always 1; pat 1: ready 1,0,0,1 repeating from the first micro-op.
  task automatic run_seq(input int pat, input int flush_idx, input bit keep_valid,
                         input int exp_hold, input int exp_shr);
    int n_acc = 0, n_hold = 0, n_shr = 0, last_c = -1, done_c = -1;
    bit fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("trig_hold", m_hold, 1);
        chk("trig_active", m_act, 1);
        chk("trig_valid", m_valid, 0);
      end
      if (m_hold) n_hold++;
      if (m_done) begin
        done_c = c;
        fin = 1'b1;
        chk("done_hold", m_hold, 0);
        chk("done_active", m_act, 0);
      end else if (m_valid) begin
        if (n_acc < exp_q.size()) chk("uop_fields", m_fld, exp_q[n_acc]);
        else chk("uop_extra", n_acc, exp_q.size());
        if (flush_idx == n_acc) begin
          flush = 1'b1;
          fin = 1'b1;
        end else if (rdy) begin
          if (m_fld[19:16] == UOP_SHR) n_shr++;
          if (m_last) last_c = c;
          n_acc++;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (!keep_valid) ivalid = 1'b0;
        rdy = (pat == 0) || (c % 4 == 0) || (c % 4 == 3);
      end
    end
    chk("finished", fin, 1);
    if (flush_idx >= 0) begin
      chk("flush_accepted", n_acc, flush_idx);
    end else begin
      chk("uop_count", n_acc, exp_q.size());
      chk("shr_count", n_shr, exp_shr);
      chk("hold_cycles", n_hold, exp_hold);
      chk("done_gap", done_c - last_c, 1);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    rdy = 1'b1;
    if (!keep_valid) ivalid = 1'b0;
    @(negedge clk);
    chk("after_valid", m_valid, 0);
    chk("after_done", m_done, 0);
    chk("after_hold", m_hold, keep_valid);
    chk("after_active", m_act, keep_valid);
    chk("after_fields", m_fld, 0);
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; flush = 1'b0; rdy = 1'b1; instr = 32'd0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_a", {hold_a, act_a, done_a, ua.uop_valid, ua.uop_last}, 0);
    chk("rst_fields_a", {ua.uop_op, ua.uop_rd, ua.uop_rn, ua.uop_rm}, 0);
    chk("rst_outs_b", {hold_b, act_b, done_b, ub.uop_valid, ub.uop_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-MUL opcode, then MUL opcode without ifid_valid.
    instr = mk_instr(7'b0010001, 4'd2, 4'd3, 4'd4);
    ivalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        instr = mk_instr(OPC_MUL, 4'd2, 4'd3, 4'd4);
        ivalid = 1'b0;
      end
      @(negedge clk);
      chk("idle_quiet", {hold_a, act_a, done_a, ua.uop_valid, hold_b, act_b, done_b,
                         ub.uop_valid}, 0);
      @(posedge clk); #1;
    end

    // MULS on the LOOP_N=4 instance, free-running then with backpressure.
    sel = 1'b1;
    build(1'b1, 4, 4'd1, 4'd5, 4'd6);
    instr = mk_instr(OPC_MULS, 4'd1, 4'd5, 4'd6);
    ivalid = 1'b1;
    run_seq(0, -1, 1'b0, 18, 4);
    @(posedge clk); #1;
    ivalid = 1'b1;
    run_seq(1, -1, 1'b0, 34, 4);

    // Reset in the middle of a sequence.
    @(posedge clk); #1;
    instr = mk_instr(OPC_MUL, 4'd2, 4'd3, 4'd4);
    ivalid = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_a", {hold_a, act_a, done_a, ua.uop_valid, ua.uop_last, ua.uop_op}, 0);
    chk("rst_mid_b", {hold_b, act_b, done_b, ub.uop_valid, ub.uop_last, ub.uop_op}, 0);

    // MUL on the LOOP_N=32 instance.
    sel = 1'b0;
    build(1'b0, 32, 4'd2, 4'd3, 4'd4);
    @(posedge clk); #1;
    ivalid = 1'b1;
    run_seq(0, -1, 1'b0, 101, 32);

    // Flush on the 40th micro-op, then a clean retrigger from entry 0.
    @(posedge clk); #1;
    ivalid = 1'b1;
    run_seq(0, 39, 1'b0, 0, 0);
    @(posedge clk); #1;
    ivalid = 1'b1;
    run_seq(0, -1, 1'b0, 101, 32);

    // Back-to-back MUL left valid in IF/ID: no retrigger in DONE, retrigger in next IDLE.
    @(posedge clk); #1;
    ivalid = 1'b1;
    run_seq(0, -1, 1'b1, 101, 32);
    @(posedge clk); #1;
    ivalid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", m_valid, 1);
    chk("b2b_first", m_fld, exp_q[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
